glyph_plotter: RTL and testbench

Reusable 16x16 instruction-glyph rasteriser. One instance sits upstream of the instruction mux for each drawn or cleared glyph. Under a level-sensitive enable it scans a fixed box pixel by pixel and emits x/y/colour/plot for the 160x120 VGA adapter. It raises done when the scan completes and holds it until enable drops, which matches the mux controller's done-high/done-low wait handshake.

---
 rtl/glyph_plotter.sv | 168 ++++++++++++++++
 tb/tb_glyph_plotter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_plotter.sv
// Scans a fixed 16x16 screen box one pixel per cycle and emits x/y/colour/plot
// for one instruction glyph, or paints the whole box black when clear is latched.
module glyph_plotter #(
    parameter int ORIGIN_X = 72,
    parameter int ORIGIN_Y = 52
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [2:0] glyph_id,
    input  logic       clear,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    // Handshake: enable is a level request. Raising it in IDLE starts a scan,
    // done holds high after the scan until enable is sampled low, and dropping
    // enable mid-scan abandons the draw without ever raising done.
    // busy/done together encode the FSM state (neither high means IDLE).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] GLYPH_UP    = 3'b000;
    localparam logic [2:0] GLYPH_DOWN  = 3'b001;
    localparam logic [2:0] GLYPH_RIGHT = 3'b010;
    localparam logic [2:0] GLYPH_LEFT  = 3'b011;
    localparam logic [2:0] GLYPH_R     = 3'b100;
    localparam logic [2:0] GLYPH_L     = 3'b101;

    state_t     state;
    state_t     state_next;
    logic [3:0] col;
    logic [3:0] row;
    logic [2:0] glyph_l;
    logic       clear_l;
    logic       last_pixel;
    logic       pixel_on;

    function automatic logic in_range(input logic [3:0] v,
                                      input logic [3:0] lo,
                                      input logic [3:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Arrow pointing up: vertical stem plus a triangular head widening downwards.
    function automatic logic up_bit(input logic [3:0] c, input logic [3:0] r);
        logic stem;
        logic head;
        stem = ((c == 4'd7) || (c == 4'd8)) && in_range(r, 4'd2, 4'd13);
        head = in_range(r, 4'd2, 4'd7)
               && ({1'b0, c} >= (5'd9 - {1'b0, r}))
               && ({1'b0, c} <= (5'd6 + {1'b0, r}));
        return stem || head;
    endfunction

    function automatic logic l_bit(input logic [3:0] c, input logic [3:0] r);
        return (in_range(c, 4'd3, 4'd5) && in_range(r, 4'd2, 4'd13))
            || (in_range(r, 4'd11, 4'd13) && in_range(c, 4'd3, 4'd12));
    endfunction

    function automatic logic r_bit(input logic [3:0] c, input logic [3:0] r);
        logic spine;
        logic bars;
        logic bowl;
        logic leg;
        spine = in_range(c, 4'd3, 4'd5) && in_range(r, 4'd2, 4'd13);
        bars  = ((r == 4'd2) || (r == 4'd3) || (r == 4'd7) || (r == 4'd8))
                && in_range(c, 4'd3, 4'd11);
        bowl  = in_range(c, 4'd10, 4'd12) && in_range(r, 4'd2, 4'd8);
        leg   = in_range(r, 4'd9, 4'd13)
                && (({1'b0, c} + 5'd1) >= {1'b0, r})
                && ({1'b0, c} <= ({1'b0, r} + 5'd1));
        return spine || bars || bowl || leg;
    endfunction

    // The other arrows reuse the UP bitmap: 15-v on a 4-bit coordinate is ~v.
    always_comb begin
        pixel_on = 1'b0;
        case (glyph_l)
            GLYPH_UP:    pixel_on = up_bit(col, row);
            GLYPH_DOWN:  pixel_on = up_bit(col, ~row);
            GLYPH_LEFT:  pixel_on = up_bit(row, col);
            GLYPH_RIGHT: pixel_on = up_bit(row, ~col);
            GLYPH_R:     pixel_on = r_bit(col, row);
            GLYPH_L:     pixel_on = l_bit(col, row);
            default:     pixel_on = 1'b0;
        endcase
    end

    always_comb begin
        colour = 3'b000;
        if (!clear_l) begin
            case (glyph_l)
                GLYPH_UP:    colour = 3'b111;
                GLYPH_DOWN:  colour = 3'b001;
                GLYPH_RIGHT: colour = 3'b011;
                GLYPH_LEFT:  colour = 3'b010;
                GLYPH_R:     colour = 3'b100;
                GLYPH_L:     colour = 3'b101;
                default:     colour = 3'b000;
            endcase
        end
    end

    assign last_pixel = (col == 4'd15) && (row == 4'd15);
    assign x = 8'(ORIGIN_X) + {4'b0000, col};
    assign y = 7'(ORIGIN_Y) + {3'b000, row};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        plot       = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = DRAW;
            end
            DRAW: begin
                busy = 1'b1;
                plot = clear_l || pixel_on;
                if (!enable) begin
                    state_next = IDLE;
                end else if (last_pixel) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset latches an invalid glyph so colour idles at black.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            col     <= 4'd0;
            row     <= 4'd0;
            glyph_l <= 3'b111;
            clear_l <= 1'b0;
        end else if ((state == IDLE) && enable) begin
            col     <= 4'd0;
            row     <= 4'd0;
            glyph_l <= glyph_id;
            clear_l <= clear;
        end else if (state == DRAW) begin
            col <= col + 4'd1;
            if (col == 4'd15) row <= row + 4'd1;
        end
    end

endmodule

// File: tb/tb_glyph_plotter.sv
// Directed bench for glyph_plotter: table of full-scan vectors checked against a
// bitmap model, plus hand sequences for abort, reset and done handshake corners.
module tb_glyph_plotter;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic [2:0] glyph_id;
    logic       clear;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_checks;
    int n_pass;
    bit hit[16][16];

    typedef struct {
        logic [2:0] glyph;
        logic       clr;
        logic       mid_change;
        int         exp_count;
        logic [2:0] exp_colour;
        int         exp_fx;
        int         exp_fy;
    } vec_t;

    vec_t vecs[9];

    glyph_plotter #(.ORIGIN_X(72), .ORIGIN_Y(52)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable),
        .glyph_id (glyph_id),
        .clear    (clear),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // reference bitmaps written straight from the coordinate rules
    function automatic bit up_m(input int c, input int r);
        return ((c == 7 || c == 8) && r >= 2 && r <= 13)
            || (r >= 2 && r <= 7 && c >= 9 - r && c <= 6 + r);
    endfunction

    function automatic bit model_bit(input int g, input bit clr, input int c, input int r);
        if (clr) return 1'b1;
        case (g)
            0: return up_m(c, r);
            1: return up_m(c, 15 - r);
            3: return up_m(r, c);
            2: return up_m(r, 15 - c);
            4: return (c >= 3 && c <= 5 && r >= 2 && r <= 13)
                   || ((r == 2 || r == 3 || r == 7 || r == 8) && c >= 3 && c <= 11)
                   || (c >= 10 && c <= 12 && r >= 2 && r <= 8)
                   || (r >= 9 && r <= 13 && c >= r - 1 && c <= r + 1);
            5: return (c >= 3 && c <= 5 && r >= 2 && r <= 13)
                   || (r >= 11 && r <= 13 && c >= 3 && c <= 12);
            default: return 1'b0;
        endcase
    endfunction

    // driver: one full scan with enable held, then the done handshake
    task automatic run_vec(input int idx, input vec_t v);
        int cnt, fx, fy, col_err, bmp_err, done_cyc, bad, c, r;
        bit exp_p;
        cnt = 0; fx = -1; fy = -1; col_err = 0; bmp_err = 0; done_cyc = -1; bad = 0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) hit[i][j] = 1'b0;
        @(negedge clock);
        glyph_id = v.glyph;
        clear    = v.clr;
        enable   = 1'b1;
        @(posedge clock);
        for (int n = 1; n <= 300; n++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                done_cyc = n;
                break;
            end
            if (n <= 256) begin
                c = (n - 1) % 16;
                r = (n - 1) / 16;
                exp_p = model_bit(int'(v.glyph), v.clr, c, r);
                if (plot !== exp_p || busy !== 1'b1 || x !== 8'(72 + c) || y !== 7'(52 + r))
                    bmp_err++;
                if (colour !== v.exp_colour) col_err++;
                if (plot === 1'b1) begin
                    cnt++;
                    hit[c][r] = 1'b1;
                    if (fx < 0) begin
                        fx = int'(x);
                        fy = int'(y);
                    end
                end
            end
            if (v.mid_change && n == 128) begin
                glyph_id = 3'b000;
                clear    = 1'b0;
            end
        end
        check($sformatf("v%0d_plot_count", idx), cnt, v.exp_count);
        check($sformatf("v%0d_colour_errs", idx), col_err, 0);
        check($sformatf("v%0d_pixel_errs", idx), bmp_err, 0);
        check($sformatf("v%0d_done_cycle", idx), done_cyc, 257);
        if (v.exp_count > 0) begin
            check($sformatf("v%0d_first_x", idx), fx, v.exp_fx);
            check($sformatf("v%0d_first_y", idx), fy, v.exp_fy);
        end
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            if (done !== 1'b1 || plot !== 1'b0 || busy !== 1'b0) bad++;
        end
        check($sformatf("v%0d_done_hold_bad", idx), bad, 0);
        enable = 1'b0;
        @(negedge clock);
        check($sformatf("v%0d_done_fall", idx), int'(done), 0);
        check($sformatf("v%0d_idle_busy", idx), int'(busy), 0);
    endtask

    initial begin
        int bad;
        bit reached;
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        enable   = 1'b0;
        glyph_id = 3'b000;
        clear    = 1'b0;

        vecs[0] = '{3'd0, 1'b0, 1'b0,  54, 3'b111, 79, 54};  // UP
        vecs[1] = '{3'd1, 1'b0, 1'b0,  54, 3'b001, 79, 54};  // DOWN
        vecs[2] = '{3'd2, 1'b0, 1'b0,  54, 3'b011, 80, 54};  // RIGHT
        vecs[3] = '{3'd3, 1'b0, 1'b0,  54, 3'b010, 79, 54};  // LEFT
        vecs[4] = '{3'd4, 1'b0, 1'b0,  88, 3'b100, 75, 54};  // R
        vecs[5] = '{3'd5, 1'b0, 1'b0,  57, 3'b101, 75, 54};  // L
        vecs[6] = '{3'd3, 1'b1, 1'b1, 256, 3'b000, 72, 52};  // clear, glyph changed mid-scan
        vecs[7] = '{3'd6, 1'b0, 1'b0,   0, 3'b000, 0, 0};    // invalid
        vecs[8] = '{3'd7, 1'b1, 1'b0, 256, 3'b000, 72, 52};  // invalid + clear

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_x", int'(x), 72);
        check("rst_y", int'(y), 52);
        check("rst_colour", int'(colour), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
            if (i == 5) begin
                check("l_has_75_54", int'(hit[3][2]), 1);
                check("l_has_84_65", int'(hit[12][13]), 1);
                check("l_not_81_58", int'(hit[9][6]), 0);
            end
        end

        // abort at pixel 100, then restart from (0,0)
        @(negedge clock);
        glyph_id = 3'b000;
        clear    = 1'b0;
        enable   = 1'b1;
        @(posedge clock);
        for (int n = 1; n <= 101; n++) @(negedge clock);
        check("abort_pix100_plot", int'(plot), 1);
        check("abort_pix100_x", int'(x), 76);
        enable = 1'b0;
        @(negedge clock);
        check("abort_plot_off", int'(plot), 0);
        check("abort_busy_off", int'(busy), 0);
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (done !== 1'b0) bad++;
        end
        check("abort_done_low", bad, 0);
        run_vec(9, vecs[0]);

        // reset mid-DRAW
        @(negedge clock);
        glyph_id = 3'b000;
        enable   = 1'b1;
        @(posedge clock);
        for (int n = 1; n <= 49; n++) @(negedge clock);
        check("pre_rst_busy", int'(busy), 1);
        reset_n = 1'b0;
        @(negedge clock);
        check("mid_rst_x", int'(x), 72);
        check("mid_rst_y", int'(y), 52);
        check("mid_rst_colour", int'(colour), 0);
        check("mid_rst_plot", int'(plot), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        enable  = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);

        // reset while holding DONE
        enable = 1'b1;
        reached = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                reached = 1'b1;
                break;
            end
        end
        check("done_reached", int'(reached), 1);
        reset_n = 1'b0;
        @(negedge clock);
        check("done_rst_done", int'(done), 0);
        check("done_rst_busy", int'(busy), 0);
        check("done_rst_colour", int'(colour), 0);
        enable  = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
